// File: rtl/uart_ctrl.sv
// UART controller: baud tick generator, RX FIFO, TX hold register and launch FSM, register bus.
// Optional interrupt output and enables are built when UART_CTRL_IRQ_EN is defined.
module uart_ctrl #(
  parameter int unsigned BAUD_DIV = 326,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        sysclk,
  input  logic        reset,
`ifdef UART_CTRL_IRQ_EN
  output logic        irq,
`endif
  output logic        baud_tick,
  output logic        rx_en,
  input  logic        rx_status,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic [1:0]  addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  state_t          state_q, state_d;
  logic [15:0]     div_q, div_d, cnt_q, cnt_d;
  logic            rx_en_q, rx_en_d, tx_en_q, tx_en_d;
  logic            ovr_q, ovr_d, drop_q, drop_d;
  logic [7:0]      hold_q, hold_d, tx_data_q, tx_data_d;
  logic            hold_full_q, hold_full_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]   fcnt_q, fcnt_d;
  logic            wr_txd_s, wr_con_s, wr_div_s, rd_rxd_s;
  logic            push_req_s, push_s, pop_s, full_s, empty_s, launch_s;
  logic [31:0]     con_s;
  logic            unused_s;
`ifdef UART_CTRL_IRQ_EN
  logic            rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d, irq_q, irq_d;
`endif

  assign wr_txd_s = wr & (addr == 2'd0);
  assign rd_rxd_s = rd & (addr == 2'd1);
  assign wr_con_s = wr & (addr == 2'd2);
  assign wr_div_s = wr & (addr == 2'd3);
  assign unused_s = ^wdata;

  assign baud_tick  = (div_q <= 16'd1) | (cnt_q == (div_q - 16'd1));
  assign rx_en      = rx_en_q;
  assign tx_start   = (state_q == S_LAUNCH);
  assign tx_data    = tx_data_q;

  assign full_s     = (fcnt_q == CW'(DEPTH));
  assign empty_s    = (fcnt_q == {CW{1'b0}});
  assign push_req_s = rx_status & rx_en_q;
  assign pop_s      = rd_rxd_s & ~empty_s;
  // A full FIFO still accepts a push when a pop frees the head slot at the same edge.
  assign push_s     = push_req_s & (~full_s | pop_s);

`ifdef UART_CTRL_IRQ_EN
  assign irq   = irq_q;
  assign con_s = {18'd0, tx_ie_q, rx_ie_q, 5'(fcnt_q), drop_q, ovr_q, ~empty_s,
                  tx_busy, hold_full_q, tx_en_q, rx_en_q};
`else
  assign con_s = {20'd0, 5'(fcnt_q), drop_q, ovr_q, ~empty_s,
                  tx_busy, hold_full_q, tx_en_q, rx_en_q};
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (hold_full_q && tx_en_q) state_d = S_LAUNCH; else state_d = S_IDLE;
      S_LAUNCH:    state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (tx_busy) state_d = S_WAIT_DONE; else state_d = S_WAIT_BUSY;
      S_WAIT_DONE: if (!tx_busy) state_d = S_IDLE; else state_d = S_WAIT_DONE;
      default:     state_d = S_IDLE;
    endcase
  end

  assign launch_s = (state_q == S_IDLE) && (state_d == S_LAUNCH);

  always_comb begin
    div_d       = div_q;
    cnt_d       = cnt_q + 16'd1;
    rx_en_d     = rx_en_q;
    tx_en_d     = tx_en_q;
    ovr_d       = ovr_q;
    drop_d      = drop_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_data_d   = tx_data_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    fcnt_d      = fcnt_q;
    if (wr_div_s) begin
      div_d = wdata[15:0];
      cnt_d = 16'd0;
    end else if (baud_tick) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
    if (wr_con_s) begin
      rx_en_d = wdata[0];
      tx_en_d = wdata[1];
    end else begin
      rx_en_d = rx_en_q;
    end
    // Sticky flags: a new event in the same cycle outranks the write-1-to-clear.
    if (push_req_s && full_s && !pop_s) ovr_d = 1'b1;
    else if (wr_con_s && wdata[5]) ovr_d = 1'b0;
    else ovr_d = ovr_q;
    if (wr_txd_s && hold_full_q) drop_d = 1'b1;
    else if (wr_con_s && wdata[6]) drop_d = 1'b0;
    else drop_d = drop_q;
    if (launch_s) begin
      hold_full_d = 1'b0;
      tx_data_d   = hold_q;
    end else if (wr_txd_s && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_d      = wdata[7:0];
    end else begin
      hold_full_d = hold_full_q;
    end
    if (push_s) wp_d = wp_q + AW'(1); else wp_d = wp_q;
    if (pop_s) rp_d = rp_q + AW'(1); else rp_d = rp_q;
    case ({push_s, pop_s})
      2'b10:   fcnt_d = fcnt_q + CW'(1);
      2'b01:   fcnt_d = fcnt_q - CW'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

`ifdef UART_CTRL_IRQ_EN
  always_comb begin
    rx_ie_d = rx_ie_q;
    tx_ie_d = tx_ie_q;
    if (wr_con_s) begin
      rx_ie_d = wdata[12];
      tx_ie_d = wdata[13];
    end else begin
      tx_ie_d = tx_ie_q;
    end
    irq_d = (rx_ie_q & ~empty_s) | (tx_ie_q & ~hold_full_q & (state_q == S_IDLE)) | ovr_q;
  end
`endif

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_q       <= 16'(BAUD_DIV);
      cnt_q       <= 16'd0;
      rx_en_q     <= 1'b1;
      tx_en_q     <= 1'b1;
      ovr_q       <= 1'b0;
      drop_q      <= 1'b0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      tx_data_q   <= 8'd0;
      wp_q        <= {AW{1'b0}};
      rp_q        <= {AW{1'b0}};
      fcnt_q      <= {CW{1'b0}};
`ifdef UART_CTRL_IRQ_EN
      rx_ie_q     <= 1'b0;
      tx_ie_q     <= 1'b0;
      irq_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      rx_en_q     <= rx_en_d;
      tx_en_q     <= tx_en_d;
      ovr_q       <= ovr_d;
      drop_q      <= drop_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_data_q   <= tx_data_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      fcnt_q      <= fcnt_d;
`ifdef UART_CTRL_IRQ_EN
      rx_ie_q     <= rx_ie_d;
      tx_ie_q     <= tx_ie_d;
      irq_q       <= irq_d;
`endif
    end
  end

  // FIFO storage needs no reset; the pointers and count define which entries are valid.
  always_ff @(posedge sysclk) begin
    if (push_s) mem_q[wp_q] <= rx_data;
  end

  always_comb begin
    rdata = 32'd0;
    if (rd) begin
      case (addr)
        2'd1:    if (!empty_s) rdata = {24'd0, mem_q[rp_q]}; else rdata = 32'd0;
        2'd2:    rdata = con_s;
        2'd3:    rdata = {16'd0, div_q};
        default: rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: directed scenarios plus randomized RX/TX traffic vs a queue model.
module tb_uart_ctrl;
  localparam int DEPTH    = 4;
  localparam int BAUD_DIV = 326;

  logic        sysclk = 1'b0;
  logic        reset, baud_tick, rx_en, rx_status, tx_start, tx_busy, rd, wr;
  logic [7:0]  rx_data, tx_data;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  int checks = 0;
  int errors = 0;

  uart_ctrl #(.BAUD_DIV(BAUD_DIV), .DEPTH(DEPTH)) dut (
    .sysclk(sysclk), .reset(reset), .baud_tick(baud_tick), .rx_en(rx_en),
    .rx_status(rx_status), .rx_data(rx_data), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .addr(addr), .rd(rd), .wr(wr), .wdata(wdata), .rdata(rdata)
  );

  always #5 sysclk = ~sysclk;

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    step();
    wr = 1'b0; wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    #2;
    d = rdata;
    step();
    rd = 1'b0;
  endtask

  function automatic logic [31:0] con_val(input bit rxe, input bit txe, input bit hf, input bit busy,
                                          input int cnt, input bit ovr, input bit drop);
    return 32'(rxe) | (32'(txe) << 1) | (32'(hf) << 2) | (32'(busy) << 3) |
           (32'(cnt != 0) << 4) | (32'(ovr) << 5) | (32'(drop) << 6) | (32'(cnt) << 7);
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; rx_status = 1'b0; rx_data = 8'd0; tx_busy = 1'b0;
    addr = 2'd0; rd = 1'b0; wr = 1'b0; wdata = 32'd0;
    repeat (3) step();
    checks++; if ({baud_tick, tx_start, tx_data, rdata, rx_en} !== {1'b0, 1'b0, 8'd0, 32'd0, 1'b1}) begin
      errors++; $display("FAIL reset_outputs: got tick=%b start=%b txd=%h rdata=%h rx_en=%b", baud_tick, tx_start, tx_data, rdata, rx_en);
    end
    reset = 1'b0;
    step();
    bus_read(2'd2, v);
    checks++; if (v !== 32'h3) begin errors++; $display("FAIL reset_con: got %h expected %h", v, 32'h3); end
    bus_read(2'd3, v);
    checks++; if (v !== 32'(BAUD_DIV)) begin errors++; $display("FAIL reset_div: got %0d expected %0d", v, BAUD_DIV); end
  endtask

  task automatic test_baud();
    logic [31:0] v;
    int d;
    bus_write(2'd3, 32'd4);
    for (int i = 0; i < 12; i++) begin
      checks++; if (baud_tick !== (((i + 1) % 4) == 0)) begin errors++; $display("FAIL baud_div4 cyc %0d: got %b", i, baud_tick); end
      step();
    end
    d = $urandom_range(2, 9);
    bus_write(2'd3, 32'(d));
    for (int i = 0; i < 3 * d; i++) begin
      checks++; if (baud_tick !== (((i + 1) % d) == 0)) begin errors++; $display("FAIL baud_div%0d cyc %0d: got %b", d, i, baud_tick); end
      step();
    end
    bus_read(2'd3, v);
    checks++; if (v !== 32'(d)) begin errors++; $display("FAIL div_readback: got %0d expected %0d", v, d); end
    bus_write(2'd3, 32'd0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (baud_tick !== 1'b1) begin errors++; $display("FAIL baud_div0 cyc %0d: got %b expected 1", i, baud_tick); end
      step();
    end
    bus_write(2'd3, 32'd1);
    for (int i = 0; i < 6; i++) begin
      checks++; if (baud_tick !== 1'b1) begin errors++; $display("FAIL baud_div1 cyc %0d: got %b expected 1", i, baud_tick); end
      step();
    end
  endtask

  task automatic test_tx_basic();
    logic [31:0] v;
    tx_busy = 1'b0;
    bus_write(2'd0, 32'h5A);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL tx_early: got %b expected 0", tx_start); end
    step();
    checks++; if ({tx_start, tx_data} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL tx_launch: got start=%b data=%h expected 1/5a", tx_start, tx_data); end
    bus_read(2'd2, v);
    checks++; if (v[2] !== 1'b0) begin errors++; $display("FAIL tx_hold_clear: got %b expected 0", v[2]); end
    tx_busy = 1'b1;
    bus_write(2'd0, 32'hC3);
    for (int i = 0; i < 4; i++) begin
      checks++; if ({tx_start, tx_data} !== {1'b0, 8'h5A}) begin errors++; $display("FAIL tx_held cyc %0d: got start=%b data=%h", i, tx_start, tx_data); end
      step();
    end
    tx_busy = 1'b0;
    step();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL tx_second_early: got %b expected 0", tx_start); end
    step();
    checks++; if ({tx_start, tx_data} !== {1'b1, 8'hC3}) begin errors++; $display("FAIL tx_second_launch: got start=%b data=%h expected 1/c3", tx_start, tx_data); end
    step();
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL tx_pulse_width: got %b expected 0", tx_start); end
    tx_busy = 1'b1; step(); tx_busy = 1'b0; step(); step();
  endtask

  task automatic test_tx_drop();
    logic [31:0] v;
    int seen;
    bus_write(2'd0, 32'hA5);
    bus_write(2'd0, 32'h3C);
    checks++; if ({tx_start, tx_data} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL drop_first_launch: got start=%b data=%h expected 1/a5", tx_start, tx_data); end
    bus_read(2'd2, v);
    checks++; if ({v[6], v[2]} !== 2'b10) begin errors++; $display("FAIL drop_flag: got drop=%b hold=%b expected 1/0", v[6], v[2]); end
    tx_busy = 1'b1; step(); tx_busy = 1'b0; step();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (tx_start) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL drop_no_launch: got %0d launches expected 0", seen); end
    bus_write(2'd2, 32'h40);
    checks++; if (rx_en !== 1'b0) begin errors++; $display("FAIL con_rx_en_port: got %b expected 0", rx_en); end
    bus_read(2'd2, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL drop_clear: got %h expected 0", v); end
    bus_write(2'd2, 32'h3);
  endtask

  task automatic test_tx_enable();
    logic [31:0] v;
    int seen;
    bus_write(2'd2, 32'h1);
    bus_write(2'd0, 32'h99);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (tx_start) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL txen_blocked: got %0d launches expected 0", seen); end
    bus_read(2'd2, v);
    checks++; if (v !== 32'h5) begin errors++; $display("FAIL txen_con: got %h expected 5", v); end
    bus_write(2'd2, 32'h3);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL txen_early: got %b expected 0", tx_start); end
    step();
    checks++; if ({tx_start, tx_data} !== {1'b1, 8'h99}) begin errors++; $display("FAIL txen_launch: got start=%b data=%h expected 1/99", tx_start, tx_data); end
    tx_busy = 1'b1; step(); step(); tx_busy = 1'b0; step();
  endtask

  task automatic test_rx_overrun();
    logic [31:0] v;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'h11 + 8'(i); rx_status = 1'b1;
      step();
      rx_status = 1'b0;
    end
    bus_read(2'd2, v);
    checks++; if (v !== con_val(1, 1, 0, 0, 4, 1, 0)) begin errors++; $display("FAIL ovr_con: got %h expected %h", v, con_val(1, 1, 0, 0, 4, 1, 0)); end
    for (int i = 0; i < 5; i++) begin
      bus_read(2'd1, v);
      checks++; if (v !== ((i < 4) ? 32'h11 + 32'(i) : 32'h0)) begin errors++; $display("FAIL ovr_read %0d: got %h", i, v); end
    end
    bus_write(2'd2, 32'h23);
    bus_read(2'd2, v);
    checks++; if (v !== 32'h3) begin errors++; $display("FAIL ovr_clear: got %h expected 3", v); end
  endtask

  task automatic test_full_pushpop();
    logic [31:0] v;
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      rx_data = b[i]; rx_status = 1'b1;
      step();
    end
    rx_data = 8'h77; rx_status = 1'b1; addr = 2'd1; rd = 1'b1;
    #2;
    v = rdata;
    step();
    rx_status = 1'b0; rd = 1'b0;
    checks++; if (v !== {24'd0, b[0]}) begin errors++; $display("FAIL pushpop_head: got %h expected %h", v, b[0]); end
    bus_read(2'd2, v);
    checks++; if (v !== con_val(1, 1, 0, 0, 4, 0, 0)) begin errors++; $display("FAIL pushpop_con: got %h expected %h", v, con_val(1, 1, 0, 0, 4, 0, 0)); end
    for (int i = 1; i < 5; i++) begin
      bus_read(2'd1, v);
      checks++; if (v !== ((i < 4) ? {24'd0, b[i]} : 32'h77)) begin errors++; $display("FAIL pushpop_read %0d: got %h", i, v); end
    end
  endtask

  task automatic test_random_rx();
    logic [7:0] q[$];
    logic [31:0] v, exp;
    bit ovr_m = 1'b0;
    bit rxen_m = 1'b1;
    int op;
    bit push;
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 7);
      push = ($urandom_range(0, 1) == 1);
      rx_data = 8'($urandom);
      rd = 1'b0; wr = 1'b0;
      if (op <= 2) begin rd = 1'b1; addr = 2'd1; end
      else if (op == 3) begin rd = 1'b1; addr = 2'd2; end
      else if (op == 4) begin
        wr = 1'b1; addr = 2'd2; push = 1'b0;
        wdata = {26'd0, 1'($urandom), 3'd0, 1'b1, 1'($urandom_range(0, 3) != 0)};
      end
      rx_status = push;
      #2;
      if (rd) begin
        if (addr == 2'd1) exp = (q.size() != 0) ? {24'd0, q[0]} : 32'd0;
        else exp = con_val(rxen_m, 1, 0, 0, q.size(), ovr_m, 0);
        checks++; if (rdata !== exp) begin errors++; $display("FAIL rand_rx op%0d n%0d: got %h expected %h", op, n, rdata, exp); end
      end
      step();
      if (rd && addr == 2'd1 && q.size() != 0) void'(q.pop_front());
      if (push && rxen_m) begin
        if (q.size() < DEPTH) q.push_back(rx_data); else ovr_m = 1'b1;
      end
      if (wr) begin
        rxen_m = wdata[0];
        if (wdata[5]) ovr_m = 1'b0;
      end
      rd = 1'b0; wr = 1'b0; rx_status = 1'b0; wdata = 32'd0;
    end
    bus_write(2'd2, 32'h23);
    while (q.size() != 0) begin
      bus_read(2'd1, v);
      exp = {24'd0, q.pop_front()};
      checks++; if (v !== exp) begin errors++; $display("FAIL rand_drain: got %h expected %h", v, exp); end
    end
  endtask

  task automatic test_random_tx();
    logic [7:0] b;
    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom);
      bus_write(2'd0, {24'd0, b});
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rand_tx_early %0d: got %b", k, tx_start); end
      step();
      checks++; if ({tx_start, tx_data} !== {1'b1, b}) begin errors++; $display("FAIL rand_tx_launch %0d: got start=%b data=%h expected 1/%h", k, tx_start, tx_data, b); end
      tx_busy = 1'b1;
      repeat ($urandom_range(2, 5)) step();
      tx_busy = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int seen;
    for (int i = 0; i < 2; i++) begin
      rx_data = 8'hE0 + 8'(i); rx_status = 1'b1; step(); rx_status = 1'b0;
    end
    bus_write(2'd0, 32'h81);
    step();
    tx_busy = 1'b1;
    step(); step();
    bus_write(2'd0, 32'h42);
    bus_read(2'd2, v);
    checks++; if (v !== con_val(1, 1, 1, 1, 2, 0, 0)) begin errors++; $display("FAIL pre_reset_con: got %h expected %h", v, con_val(1, 1, 1, 1, 2, 0, 0)); end
    reset = 1'b1; addr = 2'd1; rd = 1'b1;
    #1;
    checks++; if ({baud_tick, tx_start, tx_data, rdata, rx_en} !== {1'b0, 1'b0, 8'd0, 32'd0, 1'b1}) begin
      errors++; $display("FAIL midreset_outputs: got tick=%b start=%b txd=%h rdata=%h rx_en=%b", baud_tick, tx_start, tx_data, rdata, rx_en);
    end
    rd = 1'b0; tx_busy = 1'b0;
    step(); step();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (tx_start) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_launch: got %0d launches expected 0", seen); end
    bus_read(2'd2, v);
    checks++; if (v !== 32'h3) begin errors++; $display("FAIL midreset_con: got %h expected 3", v); end
    bus_read(2'd3, v);
    checks++; if (v !== 32'(BAUD_DIV)) begin errors++; $display("FAIL midreset_div: got %0d expected %0d", v, BAUD_DIV); end
    bus_read(2'd1, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL midreset_rxd: got %h expected 0", v); end
  endtask

  initial begin
    test_reset();
    test_baud();
    test_tx_basic();
    test_tx_drop();
    test_tx_enable();
    test_rx_overrun();
    test_full_pushpop();
    test_random_rx();
    test_random_tx();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
Memory-mapped controller that sequences the UART receive and transmit datapaths for the pipelined CPU.
- Generates the 16x-oversample baud clock-enable.
- Captures received bytes on the receiver's completion pulse into a small RX FIFO.
- Schedules transmit launches from a one-byte holding register.
- Exposes data, status and divisor registers on a simple word-addressed peripheral bus.
- Sits between the CPU's peripheral decode and the receive/transmit blocks, entirely in the sysclk domain.

Parameters:
- BAUD_DIV, 326: reset value of the divisor register; sysclk cycles per oversample tick.
- DEPTH, 4: RX FIFO entries; power of two, 2..16.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- baud_tick  out  1  one-sysclk-wide pulse every DIV cycles; oversample enable for rx/tx.
- rx_en  out  1  receiver enable; equals CON.rx_enable.
- rx_status  in  1  one-sysclk pulse from the receiver; byte complete.
- rx_data  in  8  received byte; valid while rx_status=1.
- tx_start  out  1  one-sysclk pulse; launch transmission of tx_data.
- tx_data  out  8  byte being launched; held stable until the next launch.
- tx_busy  in  1  transmitter busy flag.
- addr  in  2  register select: 0 TXD, 1 RXD, 2 CON, 3 DIV.
- rd  in  1  read strobe.
- wr  in  1  write strobe.
- wdata  in  32  write data.
- rdata  out  32  read data; combinational from addr when rd=1, else 0.

Behaviour:
- Reset values:
  - baud_tick=0, tx_start=0, tx_data=0, rdata=0.
  - DIV=BAUD_DIV; CON.rx_enable=1, CON.tx_enable=1.
  - RX FIFO empty; hold_full=0; sticky flags 0; TX FSM in IDLE; baud counter 0.
  - Reset asserted mid-operation aborts everything immediately; a pending hold byte and all FIFO contents are discarded.
- Baud generator:
  - 16-bit counter counts 0..DIV-1; baud_tick=1 in the cycle the counter equals DIV-1, then the counter wraps to 0.
  - DIV of 0 or 1 means a tick every cycle.
  - Any write to DIV loads DIV[15:0]=wdata[15:0] and clears the counter.
- CON register:
  - [0] rx_enable RW; [1] tx_enable RW.
  - [2] hold_full RO; [3] tx_busy RO; [4] rx_nonempty RO.
  - [5] rx_overrun, sticky, write-1-to-clear; [6] tx_drop, sticky, write-1-to-clear.
  - [11:7] rx_count RO; [31:12] read 0.
- TXD write:
  - Accepted only if hold_full=0 at that edge: hold<=wdata[7:0], hold_full<=1.
  - Otherwise the write is dropped and tx_drop<=1, including when a launch clears hold_full in the same cycle.
  - TXD reads return 0.
- TX FSM:
  - IDLE -> LAUNCH when hold_full=1 and tx_enable=1.
  - LAUNCH, one cycle: tx_start=1, tx_data<=hold, hold_full<=0; -> WAIT_BUSY.
  - WAIT_BUSY -> WAIT_DONE when tx_busy=1.
  - WAIT_DONE -> IDLE when tx_busy=0.
  - Launch latency is 2 edges after the write edge with tx_busy low.
  - The hold register may be refilled during WAIT_* states.
  - Clearing tx_enable never aborts a launch in progress; it only blocks the next IDLE->LAUNCH.
- RX FIFO:
  - Push rx_data when rx_status=1 and rx_enable=1; rx_status is ignored while rx_enable=0.
  - Push when full: byte dropped, rx_overrun<=1.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overrun.
  - RXD read: rdata={24'b0, head}; pop at the edge if nonempty.
  - RXD read when empty: rdata=0, no pop; a simultaneous push still lands.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally; count is 0..DEPTH.
- Bus:
  - rd and wr in the same cycle are both honoured.
  - Writes to RO bits are ignored.

Optional Feature:
UART_CTRL_IRQ_EN
- Defined:
  - Adds output port irq (1 bit, registered, reset 0).
  - Adds CON[12] rx_ie and CON[13] tx_ie, both RW and reset 0.
  - irq <= (rx_ie & rx_nonempty) | (tx_ie & ~hold_full & state==IDLE) | rx_overrun.
- Undefined: no irq port; CON[13:12] read 0 and writes to them are ignored.

Test Plan:
- Reset release, DIV=4 -> baud_tick high every 4th cycle; write DIV=1 -> tick every cycle from the next edge.
- Write TXD=0x5A with tx_busy=0 -> tx_start pulses 2 edges later, tx_data=0x5A, hold_full=0; a second TXD write in WAIT_BUSY is held until tx_busy falls, then launched.
- Two TXD writes back-to-back while in IDLE -> second write dropped, CON[6]=1; write CON=0x40 -> CON[6]=0.
- Five rx_status pulses carrying 0x11..0x15 with DEPTH=4 -> rx_count=4, rx_overrun=1; four RXD reads return 0x11..0x14; a fifth read returns 0.
- FIFO full, RXD read coincident with an rx_status pulse carrying 0x77 -> rdata=head, count stays 4, no overrun, 0x77 read last.
- Assert reset during WAIT_DONE with hold_full=1 and FIFO count=2 -> all outputs return to reset values, count=0, no tx_start after release.
